// File: rtl/axis_fifo_if.sv
// axis_fifo_if: C_DEPTH-entry synchronous AXI-Stream FIFO carrying TLAST beside TDATA, with fill level.
// Define AXIS_FIFO_PKT_MODE_EN to present data only once a complete packet (or a full FIFO) is stored.

module axis_fifo_if #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_DEPTH            = 4,
  parameter int C_ADDR_WIDTH       = $clog2(C_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [C_ADDR_WIDTH:0]         level
);

  localparam logic [C_ADDR_WIDTH:0]   CNT_FULL = (C_ADDR_WIDTH+1)'(C_DEPTH);
  localparam logic [C_ADDR_WIDTH:0]   CNT_ONE  = (C_ADDR_WIDTH+1)'(1);
  localparam logic [C_ADDR_WIDTH-1:0] PTR_ONE  = C_ADDR_WIDTH'(1);

  logic [C_AXIS_TDATA_WIDTH:0] mem [C_DEPTH];
  logic [C_AXIS_TDATA_WIDTH:0] head;
  logic [C_ADDR_WIDTH-1:0]     wr_ptr, rd_ptr;
  logic [C_ADDR_WIDTH:0]       count, count_nxt;
  logic                        ready_q;
  logic                        push, pop;

  assign s_axis_tready = ready_q;
  assign push          = s_axis_tvalid & ready_q;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign level         = count;

  always_comb begin
    // NOTE: default assignment first so every path drives count_nxt and no latch is inferred.
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (pop && !push) count_nxt = count - CNT_ONE;
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      // Ready is a registered "not full": a pop at full frees the slot only from the next cycle.
      ready_q <= (count_nxt != CNT_FULL);
    end
  end

  // NOTE: storage has no reset; validity is tracked by count alone, so stale words are never presented.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  end

  assign head         = mem[rd_ptr];
  assign m_axis_tdata = m_axis_tvalid ? head[C_AXIS_TDATA_WIDTH-1:0] : '0;
  assign m_axis_tlast = m_axis_tvalid ? head[C_AXIS_TDATA_WIDTH]     : 1'b0;

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [C_ADDR_WIDTH:0] pkt_cnt;
  logic                  pkt_inc, pkt_dec;

  assign pkt_inc = push & s_axis_tlast;
  assign pkt_dec = pop & m_axis_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (pkt_inc && !pkt_dec) begin
      pkt_cnt <= pkt_cnt + CNT_ONE;
    end else if (pkt_dec && !pkt_inc) begin
      pkt_cnt <= pkt_cnt - CNT_ONE;
    end
  end

  // A full FIFO releases data even without a stored TLAST so over-long packets cannot deadlock.
  assign m_axis_tvalid = (count != '0) && ((pkt_cnt != '0) || (count == CNT_FULL));
`else
  assign m_axis_tvalid = (count != '0);
`endif

endmodule

// File: doc/axis_fifo_if.md
Name: axis_fifo_if

Overview:
- Parametrised successor to the plain AXI-Stream pass-through stage.
- Inserts a DEPTH-entry synchronous FIFO between a slave AXI-Stream port and a master AXI-Stream port, with TLAST carried alongside TDATA.
- Decouples upstream and downstream backpressure and reports fill level.
- Sits wherever a stream needs buffering or register isolation between IP blocks.

Parameters:
- C_AXIS_TDATA_WIDTH, 32, TDATA width in bits for both ports.
- C_DEPTH, 4, number of entries. Must be a power of two, ≥2.
- C_ADDR_WIDTH, $clog2(C_DEPTH), pointer width. Derived; do not override.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  upstream data valid.
- s_axis_tready  out  1  high when FIFO not full.
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  upstream data.
- s_axis_tlast  in  1  upstream end-of-packet.
- m_axis_tvalid  out  1  high when an entry is presented downstream.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  head-of-FIFO data.
- m_axis_tlast  out  1  head-of-FIFO last flag.
- level  out  C_ADDR_WIDTH+1  current entry count, 0..C_DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: wr_ptr=0, rd_ptr=0, count=0. Outputs are s_axis_tready=0 while rst is high, then 1 from the first clk edge after release. m_axis_tvalid=0, level=0, m_axis_tdata/tlast=0. Storage contents are don't-care.
- Push: s_axis_tvalid && s_axis_tready at a clk edge writes {tlast,tdata} to mem[wr_ptr] and increments wr_ptr (wraps modulo C_DEPTH).
- Pop: m_axis_tvalid && m_axis_tready at a clk edge increments rd_ptr (wraps modulo C_DEPTH).
- Count: count += push − pop.
  - Simultaneous push and pop leave count unchanged.
  - Both pointers advance.
- s_axis_tready = (count != C_DEPTH) and not in reset. Registered, not combinational from m_axis_tready.
  - At full, a same-cycle pop does not enable a push. Throughput is 1 word/cycle whenever count < C_DEPTH.
- m_axis_tvalid = (count != 0). m_axis_tdata/tlast = mem[rd_ptr], driven from flops via a read mux. No combinational path from s_axis_* to m_axis_*.
- Latency: a word accepted at edge N is presented with m_axis_tvalid=1 after edge N, so it is consumable at edge N+1. Empty FIFO costs 1 cycle.
- AXIS rules:
  - Once m_axis_tvalid is high, m_axis_tdata/tlast stay stable until popped.
  - m_axis_tvalid never drops without a pop.
- level mirrors count. It is registered and updates on the same edge as push/pop.
- Reset mid-operation: all stored words are discarded immediately (asynchronous). m_axis_tvalid falls in the same cycle rst rises. No partial-packet recovery.
- Pointer widths are exactly C_ADDR_WIDTH bits. Wrap is by natural overflow. count is C_ADDR_WIDTH+1 bits and never exceeds C_DEPTH.

Optional Feature:
- Macro: AXIS_FIFO_PKT_MODE_EN.
- Defined (packet mode):
  - Maintain pkt_cnt, the number of complete packets stored. It increments on push with s_axis_tlast=1 and decrements on pop with m_axis_tlast=1. Simultaneous inc/dec leaves it unchanged.
  - m_axis_tvalid = (count != 0) && (pkt_cnt != 0 || count == C_DEPTH). The full override prevents deadlock on packets longer than C_DEPTH.
  - pkt_cnt resets to 0.
- Undefined: pkt_cnt logic is absent and m_axis_tvalid follows count only, as specified above.

Test Plan:
- Reset release, no traffic:
  - rst 1→0 → level=0, m_axis_tvalid=0.
  - s_axis_tready=1 from the first edge after release.
- Fill to full, C_DEPTH=4, m_axis_tready=0:
  - Push 0xA0..0xA3 → level=4, s_axis_tready=0.
  - A 5th beat 0xA4 held valid is not accepted.
  - m_axis_tdata=0xA0 stable.
- Drain with m_axis_tready=1 after fill → outputs 0xA0,0xA1,0xA2,0xA3 on consecutive edges. level 4→0, m_axis_tvalid=0 after the last beat, s_axis_tready=1 after the first pop.
- Streaming, tvalid=tready=1 for 20 cycles with incrementing data 0..19 and tlast on 9 and 19:
  - Output order 0..19 with tlast on 9 and 19.
  - level holds at 1 throughout, proving pointer wrap.
- Reset mid-stream: assert rst with level=3 → m_axis_tvalid=0 and level=0 without a clock edge. After release, the next pushed word 0x55 is the first word out.
- AXIS_FIFO_PKT_MODE_EN defined:
  - Push 3 beats without tlast → m_axis_tvalid stays 0.
  - Push a 4th beat with tlast → m_axis_tvalid=1.
  - Separately, push 4 beats with no tlast → full override gives m_axis_tvalid=1.
